// File: rtl/inst_fetch_responder_pkg.sv
// Shared constants and types for the instruction-fetch responder and its
// address-window checker.
package inst_fetch_responder_pkg;

    localparam logic [31:0] BASE_ADDR = 32'h8000_0000;
    localparam int unsigned SRAM_AW   = 20;
    localparam logic [31:0] NOP_INS   = 32'h0000_0000;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_responder_fetch_addr_check.sv
// Window/alignment checker: flags misaligned or out-of-window byte addresses
// and produces the SRAM word offset. Shared with the data-memory responder.
module fetch_addr_check
    import inst_fetch_responder_pkg::*;
#(
    parameter logic [31:0] WIN_BASE = BASE_ADDR,
    parameter int unsigned WIN_AW   = SRAM_AW
) (
    input  logic [31:0]       addr_i,
    output logic              fault_o,
    output logic [WIN_AW-1:0] off_o
);

    // 33-bit compare keeps the window end from wrapping past 2^32
    localparam logic [32:0] WIN_LO = {1'b0, WIN_BASE};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << WIN_AW);

    logic [32:0] addr_ext;

    assign addr_ext = {1'b0, addr_i};
    assign fault_o  = (addr_i[1:0] != 2'b00) || (addr_ext < WIN_LO) || (addr_ext >= WIN_HI);
    assign off_o    = WIN_AW'((addr_i - WIN_BASE) >> 2);

endmodule

// File: rtl/inst_fetch_responder.sv
// Fetch-side SRAM responder: multi-cycle SRAM read with wait states, a
// one-entry last-fetch buffer, and a fault path that returns NOP without stalling.
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        im_addr,
    output logic [31:0]        im_data,
    output logic               if_bubble,
    output logic               im_fault,
    input  logic               inv,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [31:0]        sram_data,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    fetch_state_e       state_q, state_d;
    logic               valid_q, valid_d;
    logic [31:0]        last_addr_q, last_addr_d;
    logic [31:0]        last_data_q, last_data_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;

    logic               fault_c;
    logic [SRAM_AW-1:0] off_c;
    logic               hit_c;
    logic               start_c;
    logic               done_c;

    fetch_addr_check #(
        .WIN_BASE (BASE_ADDR),
        .WIN_AW   (SRAM_AW)
    ) u_addr_check (
        .addr_i  (im_addr),
        .fault_o (fault_c),
        .off_o   (off_c)
    );

    assign hit_c   = valid_q && (im_addr == last_addr_q);
    assign start_c = (state_q == IDLE) && !hit_c && !fault_c && !inv;
    assign done_c  = (state_q == READ) && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            last_addr_q <= '0;
            last_data_q <= NOP_INS;
            req_addr_q  <= '0;
            cnt_q       <= '0;
            sram_addr_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
            req_addr_q  <= req_addr_d;
            cnt_q       <= cnt_d;
            sram_addr_q <= sram_addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_c) state_d = READ;
            READ:    if (done_c)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d     = valid_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        req_addr_d  = req_addr_q;
        cnt_d       = cnt_q;
        sram_addr_d = sram_addr_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        case (state_q)
            IDLE: begin
                if (start_c) begin
                    req_addr_d  = im_addr;
                    sram_addr_d = off_c;
                    ce_n_d      = 1'b0;
                    oe_n_d      = 1'b0;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                end else begin
                    ce_n_d = 1'b1;
                    oe_n_d = 1'b1;
                end
            end
            READ: begin
                if (!done_c) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // an invalidate on the capture edge drops the returned word
                    if (!inv) begin
                        last_data_d = sram_data;
                        last_addr_d = req_addr_q;
                        valid_d     = 1'b1;
                    end
                    ce_n_d = 1'b1;
                    oe_n_d = 1'b1;
                end
            end
            default: begin
                ce_n_d = 1'b1;
                oe_n_d = 1'b1;
            end
        endcase
        if (inv) valid_d = 1'b0;
    end

    assign im_fault  = fault_c;
    assign im_data   = hit_c ? last_data_q : NOP_INS;
    assign if_bubble = !hit_c && !fault_c;
    assign sram_addr = sram_addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = 1'b1;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder: DUT A runs with one wait state,
// DUT B with three wait states for the reset-abort scenario.
module tb_inst_fetch_responder;
    import inst_fetch_responder_pkg::*;

    localparam logic [31:0] W0 = 32'h3C01_1234;
    localparam logic [31:0] W1 = 32'h2421_0001;
    localparam logic [31:0] W2 = 32'hAC22_0008;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_a, rst_b;
    logic [31:0]        addr_a, addr_b;
    logic               inv_a, inv_b;
    logic [31:0]        data_a, data_b;
    logic               bub_a, bub_b, flt_a, flt_b;
    logic [SRAM_AW-1:0] sa_a, sa_b;
    logic [31:0]        sd_a, sd_b;
    logic               ce_a, ce_b, oe_a, oe_b, we_a, we_b;

    logic [31:0] mem [0:15];
    logic [31:0] exp_q [$];
    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] sram_rd(input logic [SRAM_AW-1:0] a);
        if (a < SRAM_AW'(16)) return mem[a[3:0]];
        return 32'hDEAD_BEEF;
    endfunction

    assign sd_a = sram_rd(sa_a);
    assign sd_b = sram_rd(sa_b);

    inst_fetch_responder #(.WAIT_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst_a), .im_addr(addr_a), .im_data(data_a),
        .if_bubble(bub_a), .im_fault(flt_a), .inv(inv_a),
        .sram_addr(sa_a), .sram_data(sd_a), .sram_ce_n(ce_a),
        .sram_oe_n(oe_a), .sram_we_n(we_a)
    );

    inst_fetch_responder #(.WAIT_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst_b), .im_addr(addr_b), .im_data(data_b),
        .if_bubble(bub_b), .im_fault(flt_b), .inv(inv_b),
        .sram_addr(sa_b), .sram_data(sd_b), .sram_ce_n(ce_b),
        .sram_oe_n(oe_b), .sram_we_n(we_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts stall cycles until the selected DUT drops if_bubble; records the
    // SRAM word address of the first access seen during the stall.
    task automatic wait_ready(input bit use_b, output int stalls, output logic [SRAM_AW-1:0] first_sa);
        bit seen;
        seen     = 1'b0;
        stalls   = 0;
        first_sa = '1;
        while ((use_b ? bub_b : bub_a) && stalls < 40) begin
            stalls++;
            tick();
            if (!seen && ((use_b ? ce_b : ce_a) == 1'b0)) begin
                first_sa = use_b ? sa_b : sa_a;
                seen     = 1'b1;
            end
        end
        if (use_b ? bub_b : bub_a) check("stall_timeout", 32'd1, 32'd0);
    endtask

    task automatic fetch(input bit use_b, input logic [31:0] addr, input logic [31:0] exp_data,
                         input int exp_stalls, input logic [SRAM_AW-1:0] exp_sa, input string tag);
        int                 stalls;
        logic [SRAM_AW-1:0] fsa;
        logic [31:0]        want;
        exp_q.push_back(exp_data);
        if (use_b) addr_b = addr; else addr_a = addr;
        #1;
        wait_ready(use_b, stalls, fsa);
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        if (exp_stalls > 0) check({tag, "_sram_addr"}, 32'(fsa), 32'(exp_sa));
        want = exp_q.pop_front();
        check({tag, "_data"}, use_b ? data_b : data_a, want);
        check({tag, "_fault"}, 32'(use_b ? flt_b : flt_a), 32'd0);
    endtask

    initial begin
        int                 stalls;
        logic [SRAM_AW-1:0] fsa;
        logic [31:0]        want;

        for (int i = 0; i < 16; i++) mem[i] = 32'(i) * 32'h0101_0101;
        mem[0] = W0;
        mem[1] = W1;
        mem[2] = W2;

        // 1: reset with the power-on PC
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        addr_a = 32'hFFFF_FFFF;
        addr_b = 32'h8000_0000;
        inv_a  = 1'b0;
        inv_b  = 1'b0;
        #2;
        check("rst_fault", 32'(flt_a), 32'd1);
        check("rst_bubble", 32'(bub_a), 32'd0);
        check("rst_data", data_a, NOP_INS);
        check("rst_ce_n", 32'(ce_a), 32'd1);
        check("rst_we_n", 32'(we_a), 32'd1);
        check("rst_b_bubble", 32'(bub_b), 32'd1);
        tick();
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_fault_no_access", 32'(ce_a), 32'd1);
        end

        // 2: first fill of word 0
        fetch(1'b0, 32'h8000_0000, W0, 3, SRAM_AW'(0), "fill_w0");

        // 3: held address is a hit, then a new word
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_bubble", 32'(bub_a), 32'd0);
            check("hold_data", data_a, W0);
        end
        fetch(1'b0, 32'h8000_0004, W1, 3, SRAM_AW'(1), "fill_w1");

        // 4: misaligned and past-window addresses
        tick();
        addr_a = 32'h8000_0002;
        #1;
        check("misalign_fault", 32'(flt_a), 32'd1);
        check("misalign_data", data_a, NOP_INS);
        check("misalign_bubble", 32'(bub_a), 32'd0);
        tick();
        check("misalign_no_access", 32'(ce_a), 32'd1);
        addr_a = 32'h8040_0000;
        #1;
        check("oow_fault", 32'(flt_a), 32'd1);
        check("oow_data", data_a, NOP_INS);
        check("oow_bubble", 32'(bub_a), 32'd0);
        tick();
        check("oow_no_access", 32'(ce_a), 32'd1);
        addr_a = 32'h7FFF_FFFC;
        #1;
        check("below_fault", 32'(flt_a), 32'd1);
        fetch(1'b0, 32'h8000_0004, W1, 0, SRAM_AW'(0), "post_fault_hit");

        // 5a: invalidate while hitting forces a re-read
        inv_a = 1'b1;
        #1;
        check("inv_cycle_bubble", 32'(bub_a), 32'd0);
        tick();
        inv_a = 1'b0;
        #1;
        check("after_inv_bubble", 32'(bub_a), 32'd1);
        fetch(1'b0, 32'h8000_0004, W1, 3, SRAM_AW'(1), "reread_w1");

        // 5b: invalidate on the capture edge discards the word and re-reads
        tick();
        exp_q.push_back(W2);
        addr_a = 32'h8000_0008;
        #1;
        check("cap_c0_bubble", 32'(bub_a), 32'd1);
        tick();
        check("cap_c1_bubble", 32'(bub_a), 32'd1);
        tick();
        check("cap_c2_bubble", 32'(bub_a), 32'd1);
        inv_a = 1'b1;
        tick();
        inv_a = 1'b0;
        #1;
        wait_ready(1'b0, stalls, fsa);
        check("cap_second_read_stalls", 32'(stalls), 32'd3);
        check("cap_second_read_addr", 32'(fsa), 32'd2);
        want = exp_q.pop_front();
        check("cap_second_read_data", data_a, want);

        // 6: three wait states, then reset in the middle of a read
        tick();
        rst_b = 1'b0;
        #1;
        wait_ready(1'b1, stalls, fsa);
        exp_q.push_back(W0);
        check("b_fill_stalls", 32'(stalls), 32'd5);
        want = exp_q.pop_front();
        check("b_fill_data", data_b, want);
        tick();
        addr_b = 32'h8000_0004;
        tick();
        tick();
        check("b_mid_read_ce_n", 32'(ce_b), 32'd0);
        rst_b = 1'b1;
        #1;
        check("b_abort_ce_n", 32'(ce_b), 32'd1);
        check("b_abort_oe_n", 32'(oe_b), 32'd1);
        check("b_abort_data", data_b, NOP_INS);
        check("b_abort_bubble", 32'(bub_b), 32'd1);
        #1;
        rst_b = 1'b0;
        fetch(1'b1, 32'h8000_0004, W1, 5, SRAM_AW'(1), "b_refill_w1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch_responder.md
Name: inst_fetch_responder

Overview:
Memory-side responder for the fetch interface. It takes `im_addr` from the fetch stage and reads the instruction from external instruction SRAM using a multi-cycle access with wait states. It returns the word on `im_data` and holds the fetch stage with `if_bubble` until the data is valid. A one-entry last-fetch buffer lets a repeated address return with no stall. Out-of-range and misaligned addresses return `NOP_INS` with a fault flag and no stall.

Parameters:
- BASE_ADDR, 32'h80000000, byte address of SRAM word 0
- SRAM_AW, 20, SRAM word-address width; mapped window is 4<<SRAM_AW bytes
- WAIT_CYCLES, 1, extra SRAM read cycles after the first; legal range 0..15
- NOP_INS, 32'h00000000, word returned on fault or when there is no valid data

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- im_addr  in  32  fetch byte address from the fetch stage
- im_data  out  32  instruction word, combinational
- if_bubble  out  1  stall to the fetch stage; the fetch stage holds its PC while this is 1
- im_fault  out  1  current im_addr is misaligned or outside the window, combinational
- inv  in  1  invalidate the last-fetch buffer (fence.i / self-modifying store)
- sram_addr  out  SRAM_AW  registered SRAM word address
- sram_data  in  32  SRAM read data
- sram_ce_n  out  1  registered chip enable, active-low
- sram_oe_n  out  1  registered output enable, active-low
- sram_we_n  out  1  constant 1 (read-only port)

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - state=IDLE, valid=0, last_addr=0, last_data=NOP_INS, cnt=0
  - sram_addr=0, sram_ce_n=1, sram_oe_n=1
  - Outputs during reset: im_data=NOP_INS; if_bubble=1 unless fault.
- Fault (combinational): fault = (im_addr[1:0]!=0) OR (im_addr < BASE_ADDR) OR (im_addr >= BASE_ADDR + 4<<SRAM_AW).
  - Compare in 33 bits so the window end cannot wrap.
  - Power-on PC 32'hFFFFFFFF therefore faults.
- Hit (combinational): hit = valid AND (im_addr == last_addr).
- Output rules:
  - im_fault = fault.
  - im_data = last_data if hit, else NOP_INS.
  - if_bubble = !hit AND !fault.
- Word offset: off = (im_addr - BASE_ADDR)[SRAM_AW+1:2].
- FSM states are IDLE and READ.
- IDLE:
  - If !hit AND !fault AND !inv: req_addr <= im_addr, sram_addr <= off, ce_n <= 0, oe_n <= 0, cnt <= WAIT_CYCLES, go to READ.
  - Otherwise stay in IDLE with ce_n=oe_n=1.
- READ:
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: last_data <= sram_data, last_addr <= req_addr, valid <= 1, ce_n <= 1, oe_n <= 1, go to IDLE.
- Latency: a new in-range address in cycle 0 holds if_bubble=1 for exactly WAIT_CYCLES+2 cycles. The hit, with data, appears in cycle WAIT_CYCLES+2.
- A hit, or a repeat of the same address, gives 0 stall cycles.
- If im_addr changes during READ, the current read completes and fills with req_addr. The next IDLE cycle mismatches and starts a new read. The stall stays high throughout.
- inv sets valid <= 0.
  - inv in the same cycle as a READ capture: valid ends 0, and the captured data is discarded.
  - inv in IDLE suppresses a read start that cycle.
- A fault address never starts a read and never changes last_addr/last_data.
- Reset mid-READ aborts the access immediately: ce_n/oe_n go to 1 asynchronously.

Decomposition:
- Shared package holds:
  - NOP_INS constant
  - BASE_ADDR constant
  - fetch state typedef {IDLE, READ}
  - constant SRAM_AW
- One natural sub-module: `fetch_addr_check`, purely combinational, computing fault and off from im_addr. It is reusable by the data-memory responder.

Test Plan:
1. Reset with im_addr=32'hFFFFFFFF -> im_fault=1, if_bubble=0, im_data=0, sram_ce_n=1; after reset release, no SRAM access.
2. im_addr=32'h80000000, SRAM word0=32'h3C011234, WAIT_CYCLES=1 -> if_bubble=1 for 3 cycles, sram_addr=0; in cycle 3 im_data=32'h3C011234 and if_bubble=0.
3. im_addr held at 32'h80000000 after a fill, then 32'h80000004 (word1=32'h24210001) -> 0 stall while held; the new address stalls 3 cycles, sram_addr=1, then returns 32'h24210001.
4. im_addr=32'h80000002 and im_addr=32'h80400000 (SRAM_AW=20) -> im_fault=1, im_data=0, if_bubble=0; last-fetch buffer unchanged, with 32'h80000004 still a hit afterwards.
5. inv pulsed while im_addr=32'h80000004 is a hit -> next cycle if_bubble=1 and a re-read occurs; inv asserted on the capture cycle -> a second read follows before the stall drops.
6. rst asserted mid-READ with WAIT_CYCLES=3 -> sram_ce_n/oe_n=1 and valid=0 immediately; after release, the same address re-reads with a full WAIT_CYCLES+2 stall.
